// File: rtl/cpu_pkg.sv
// Shared core package: opcodes, interrupt FSM encoding and vector helper.
// Imported by the interrupt sequencer and its priority encoder.
package cpu_pkg;

    localparam logic [5:0] OP_NOP    = 6'h00;
    localparam logic [5:0] OP_ALU    = 6'h01;
    localparam logic [5:0] OP_LOAD   = 6'h08;
    localparam logic [5:0] OP_STORE  = 6'h09;
    localparam logic [5:0] OP_JUMP   = 6'h10;
    localparam logic [5:0] OP_BRANCH = 6'h11;
    localparam logic [5:0] OP_RETI   = 6'h1E;

    localparam int IRQ_IDX_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ISSUE,
        IRQ_SERVICE,
        IRQ_RECOVER
    } irq_state_e;

    function automatic logic [15:0] irq_vec(
        input logic [15:0]          base,
        input logic [IRQ_IDX_W-1:0] idx,
        input int unsigned          shift
    );
        return base + (16'(idx) << shift);
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Request/jump-control bundle between peripherals, execute stage and
// the interrupt sequencer.
interface irq_sequencer_if #(
    parameter int NUM_IRQ = 4
);

    logic [NUM_IRQ-1:0] irq_req;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic [5:0]         op;
    logic               ex_ready;
    logic               interrupt;
    logic [15:0]        int_vector;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;

    modport master (
        input  irq_req, mask_we, mask_wdata, op, ex_ready,
        output interrupt, int_vector, irq_ack, pending, in_service
    );

    modport slave (
        output irq_req, mask_we, mask_wdata, op, ex_ready,
        input  interrupt, int_vector, irq_ack, pending, in_service
    );

endinterface

// File: rtl/irq_priority_enc.sv
// Combinational fixed-priority encoder; the lowest set index wins.
module irq_priority_enc
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]   eligible,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] index
);

    assign valid = |eligible;

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Edge-latched, masked, fixed-priority interrupt sequencer feeding
// jump control one interrupt at a time until RETI.
module irq_sequencer #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [15:0] VEC_BASE  = 16'hF000,
    parameter int          VEC_SHIFT = 2,
    parameter logic [5:0]  OP_RETI   = cpu_pkg::OP_RETI
) (
    input logic            clk,
    input logic            reset,
    irq_sequencer_if.master bus
);

    import cpu_pkg::*;

    irq_state_e           state;
    logic [NUM_IRQ-1:0]   irq_q;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   pend;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   clr;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   one;
    logic [IRQ_IDX_W-1:0] winner;
    logic [IRQ_IDX_W-1:0] enc_idx;
    logic                 enc_valid;
    logic                 intr;
    logic [NUM_IRQ-1:0]   ack;
    logic [15:0]          vec;
    logic                 in_svc;

    assign one      = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    assign rise     = bus.irq_req & ~irq_q;
    assign eligible = pend & mask;
    assign clr      = (state == IRQ_ISSUE) ? (one << winner) : '0;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_enc (
        .eligible (eligible),
        .valid    (enc_valid),
        .index    (enc_idx)
    );

    // A fresh edge outranks the acknowledge clear on the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= '0;
            pend  <= '0;
            mask  <= '0;
        end else begin
            irq_q <= bus.irq_req;
            pend  <= (pend & ~clr) | rise;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IRQ_IDLE;
            winner <= '0;
            vec    <= '0;
            intr   <= 1'b0;
            ack    <= '0;
            in_svc <= 1'b0;
        end else begin
            intr <= 1'b0;
            ack  <= '0;
            unique case (state)
                IRQ_IDLE: begin
                    if (enc_valid && bus.ex_ready) begin
                        winner <= enc_idx;
                        vec    <= irq_vec(VEC_BASE, enc_idx, VEC_SHIFT);
                        intr   <= 1'b1;
                        ack    <= one << enc_idx;
                        in_svc <= 1'b1;
                        state  <= IRQ_ISSUE;
                    end
                end
                IRQ_ISSUE: begin
                    state <= IRQ_SERVICE;
                end
                IRQ_SERVICE: begin
                    if (bus.op == OP_RETI) begin
                        state <= IRQ_RECOVER;
                    end
                end
                IRQ_RECOVER: begin
                    in_svc <= 1'b0;
                    state  <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt  = intr;
    assign bus.irq_ack    = ack;
    assign bus.int_vector = vec;
    assign bus.pending    = pend;
    assign bus.in_service = in_svc;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: directed scenarios then random
// traffic against a cycle-number reference model.
module tb_irq_sequencer;

    import cpu_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    irq_sequencer_if #(.NUM_IRQ(N)) bus ();

    irq_sequencer #(
        .NUM_IRQ   (N),
        .VEC_BASE  (16'hF000),
        .VEC_SHIFT (2),
        .OP_RETI   (6'h1E)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [15:0]  vec;
        logic [N-1:0] ack;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sets of bits plus the cycle numbers of issue/RETI.
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_mask = '0;
    logic [15:0]  m_vec  = '0;
    bit           m_busy = 1'b0;
    int           m_win  = 0;
    int           m_issue = 0;
    int           m_reti = -1;
    int           cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_prev = '0;
        m_pend = '0;
        m_mask = '0;
        m_vec  = '0;
        m_busy = 1'b0;
        m_win  = 0;
        m_reti = -1;
        sb.delete();
    endtask

    task automatic model_step();
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        logic [N-1:0] elig;
        exp_t         e;
        rise   = bus.irq_req & ~m_prev;
        m_prev = bus.irq_req;
        clr    = '0;
        elig   = m_pend & m_mask;
        if (!m_busy) begin
            if (bus.ex_ready && elig != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (elig[i]) begin
                        m_win = i;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_issue = cyc;
                m_reti  = -1;
                m_vec   = 16'hF000 + 16'(m_win * 4);
                e.cyc   = cyc;
                e.vec   = m_vec;
                e.ack   = N'(1) << m_win;
                sb.push_back(e);
            end
        end else begin
            if (cyc == m_issue + 1) clr[m_win] = 1'b1;
            if (m_reti >= 0) begin
                if (cyc == m_reti + 1) m_busy = 1'b0;
            end else if (cyc >= m_issue + 2 && bus.op == 6'h1E) begin
                m_reti = cyc;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        cyc++;
        if (rst_n) model_step();
    end

    // Monitor: pops the scoreboard whenever an interrupt is due.
    always @(negedge clk) begin : monitor
        bit   exp_int;
        exp_t e;
        exp_int = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("interrupt", 32'(bus.interrupt), 32'(exp_int));
        if (exp_int) begin
            e = sb.pop_front();
            chk("issue_vector", 32'(bus.int_vector), 32'(e.vec));
            chk("irq_ack", 32'(bus.irq_ack), 32'(e.ack));
        end else begin
            chk("irq_ack_idle", 32'(bus.irq_ack), 32'd0);
        end
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("in_service", 32'(bus.in_service), 32'(m_busy));
        chk("int_vector", 32'(bus.int_vector), 32'(m_vec));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wr_mask(input logic [N-1:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_we = 1'b0;
    endtask

    task automatic reti();
        bus.op = OP_RETI;
        tick();
        bus.op = OP_NOP;
    endtask

    initial begin
        bus.irq_req    = '1;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.op         = OP_NOP;
        bus.ex_ready   = 1'b1;

        // Reset held with all requests high.
        tick();
        tick();
        chk("rst_interrupt", 32'(bus.interrupt), 32'd0);
        chk("rst_ack", 32'(bus.irq_ack), 32'd0);
        chk("rst_vector", 32'(bus.int_vector), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_in_service", 32'(bus.in_service), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_pending", 32'(bus.pending), 32'hF);
        repeat (3) tick();
        chk("mask0_no_service", 32'(bus.in_service), 32'd0);
        bus.irq_req = '0;
        do_reset();

        // Single request on source 0.
        wr_mask(4'b0001);
        bus.irq_req = 4'b0001;
        tick();
        bus.irq_req = '0;
        tick();
        chk("single_int", 32'(bus.interrupt), 32'd1);
        chk("single_ack", 32'(bus.irq_ack), 32'h1);
        chk("single_vec", 32'(bus.int_vector), 32'hF000);
        chk("single_insvc", 32'(bus.in_service), 32'd1);
        tick();
        chk("single_pulse_end", 32'(bus.interrupt), 32'd0);
        reti();
        chk("recover_insvc", 32'(bus.in_service), 32'd1);
        tick();
        chk("after_reti_insvc", 32'(bus.in_service), 32'd0);

        // Two simultaneous requests: 1 before 3.
        wr_mask(4'b1111);
        bus.irq_req = 4'b1010;
        tick();
        bus.irq_req = '0;
        tick();
        chk("prio_first_vec", 32'(bus.int_vector), 32'hF004);
        tick();
        chk("prio_pending", 32'(bus.pending), 32'h8);
        reti();
        tick();
        tick();
        chk("prio_second_int", 32'(bus.interrupt), 32'd1);
        chk("prio_second_vec", 32'(bus.int_vector), 32'hF00C);
        chk("prio_second_ack", 32'(bus.irq_ack), 32'h8);
        tick();
        reti();
        tick();

        // Masked source stays pending until enabled.
        wr_mask(4'b1011);
        bus.irq_req = 4'b0100;
        tick();
        bus.irq_req = '0;
        tick();
        tick();
        chk("masked_no_int", 32'(bus.in_service), 32'd0);
        chk("masked_pending", 32'(bus.pending), 32'h4);
        wr_mask(4'b1111);
        tick();
        chk("unmask_int", 32'(bus.interrupt), 32'd1);
        chk("unmask_vec", 32'(bus.int_vector), 32'hF008);
        tick();
        reti();
        tick();

        // Stray RETI in idle, then deferral by ex_ready.
        bus.op = OP_RETI;
        tick();
        tick();
        bus.op = OP_NOP;
        chk("stray_reti", 32'(bus.in_service), 32'd0);
        bus.ex_ready = 1'b0;
        bus.irq_req  = 4'b0001;
        tick();
        bus.irq_req = '0;
        repeat (5) tick();
        chk("deferred_no_int", 32'(bus.in_service), 32'd0);
        chk("deferred_pending", 32'(bus.pending), 32'h1);
        bus.ex_ready = 1'b1;
        tick();
        chk("deferred_int", 32'(bus.interrupt), 32'd1);
        chk("deferred_vec", 32'(bus.int_vector), 32'hF000);
        tick();

        // Asynchronous reset while in service.
        bus.irq_req = 4'b0100;
        tick();
        bus.irq_req = '0;
        tick();
        chk("svc_pending", 32'(bus.pending), 32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("async_insvc", 32'(bus.in_service), 32'd0);
        chk("async_vec", 32'(bus.int_vector), 32'd0);
        chk("async_pending", 32'(bus.pending), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.op = OP_RETI;
        tick();
        tick();
        bus.op = OP_NOP;
        chk("post_rst_reti", 32'(bus.in_service), 32'd0);
        chk("post_rst_int", 32'(bus.interrupt), 32'd0);

        // Random traffic checked by the monitor.
        for (int k = 0; k < 1500; k++) begin
            bus.irq_req    = N'($urandom);
            bus.mask_we    = ($urandom_range(0, 7) == 0);
            bus.mask_wdata = N'($urandom);
            bus.op         = ($urandom_range(0, 4) == 0) ? OP_RETI
                                                         : 6'($urandom);
            bus.ex_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.irq_req = '0;
        bus.mask_we = 1'b0;
        bus.op      = OP_NOP;
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
